// File: rtl/mem_access_initiator.sv
// Data-memory bus initiator: runs one req/ack transaction per load/store and flags AdEL/AdES/DBE.
// Optional macro BUS_TIMEOUT_EN adds a REQ watchdog that ends the access with a bus error.
module mem_access_initiator #(
  parameter logic [31:0] ADDR_LIMIT     = 32'h0000_3000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        MemWrite,
  input  logic [1:0]  OpWidth,
  input  logic        LoadSigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RD,
  output logic        Exc,
  output logic [4:0]  ExcCode,
  output logic        BusReq,
  output logic        BusWE,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusByteEn,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  state_t      state, state_nx;
  logic        illegal;
  logic        tmo;
  logic [1:0]  op_w;
  logic [1:0]  op_lo;
  logic        op_sgn;
  logic        op_we;
  logic [31:0] ld_val;
  logic [15:0] ld_h;
  logic [7:0]  ld_b;

  assign illegal = (OpWidth == 2'b11)
                || (OpWidth == W_WORD && Addr[1:0] != 2'b00)
                || (OpWidth == W_HALF && Addr[0])
                || (Addr >= ADDR_LIMIT);

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;

  // An ack on the same edge as the timeout takes priority.
  assign tmo = (state == REQ) && !BusAck && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset)                           tcnt <= '0;
    else if (state == IDLE)              tcnt <= '0;
    else if (state == REQ && !BusAck)    tcnt <= tcnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = illegal ? DONE : REQ;
      REQ:     if (BusAck || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // Lane select and extension use the request captured at Start, not live inputs.
  always_comb begin
    ld_h   = op_lo[1] ? BusRData[31:16] : BusRData[15:0];
    ld_b   = BusRData[8*op_lo +: 8];
    ld_val = BusRData;
    case (op_w)
      W_HALF:  ld_val = {{16{op_sgn & ld_h[15]}}, ld_h};
      W_BYTE:  ld_val = {{24{op_sgn & ld_b[7]}}, ld_b};
      default: ld_val = BusRData;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RD        <= '0;
      Exc       <= 1'b0;
      ExcCode   <= '0;
      BusReq    <= 1'b0;
      BusWE     <= 1'b0;
      BusAddr   <= '0;
      BusWData  <= '0;
      BusByteEn <= '0;
      op_w      <= '0;
      op_lo     <= '0;
      op_sgn    <= 1'b0;
      op_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          if (illegal) begin
            Exc     <= 1'b1;
            ExcCode <= MemWrite ? 5'd5 : 5'd4;
          end else begin
            BusReq  <= 1'b1;
            BusWE   <= MemWrite;
            BusAddr <= {Addr[31:2], 2'b00};
            op_w    <= OpWidth;
            op_lo   <= Addr[1:0];
            op_sgn  <= LoadSigned;
            op_we   <= MemWrite;
            case (OpWidth)
              W_HALF: begin
                BusByteEn <= Addr[1] ? 4'b1100 : 4'b0011;
                BusWData  <= {2{WD[15:0]}};
              end
              W_BYTE: begin
                BusByteEn <= 4'b0001 << Addr[1:0];
                BusWData  <= {4{WD[7:0]}};
              end
              default: begin
                BusByteEn <= 4'b1111;
                BusWData  <= WD;
              end
            endcase
          end
        end
        REQ: if (BusAck || tmo) begin
          BusReq    <= 1'b0;
          BusWE     <= 1'b0;
          BusByteEn <= '0;
          if (BusAck) begin
            if (!op_we) RD <= ld_val;
          end else begin
            Exc     <= 1'b1;
            ExcCode <= 5'd7;
          end
        end
        DONE: begin
          Exc     <= 1'b0;
          ExcCode <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed + randomized bench for mem_access_initiator against a byte-lane arithmetic model.
module tb_mem_access_initiator;
  localparam logic [31:0] LIMIT = 32'h0000_3000;

  logic        Clk = 1'b0;
  logic        Reset, Start, MemWrite, LoadSigned, BusAck;
  logic [1:0]  OpWidth;
  logic [31:0] Addr, WD, BusRData;
  logic        Busy, Done, Exc, BusReq, BusWE;
  logic [4:0]  ExcCode;
  logic [31:0] RD, BusAddr, BusWData;
  logic [3:0]  BusByteEn;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd_exp;

  always #5 Clk = ~Clk;

  mem_access_initiator #(.ADDR_LIMIT(LIMIT), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MemWrite(MemWrite), .OpWidth(OpWidth),
    .LoadSigned(LoadSigned), .Addr(Addr), .WD(WD), .Busy(Busy), .Done(Done), .RD(RD),
    .Exc(Exc), .ExcCode(ExcCode), .BusReq(BusReq), .BusWE(BusWE), .BusAddr(BusAddr),
    .BusWData(BusWData), .BusByteEn(BusByteEn), .BusAck(BusAck), .BusRData(BusRData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_exc"}, {Exc, ExcCode}, 0);
    chk({tag, "_req"}, {BusReq, BusWE, BusByteEn}, 0);
    chk({tag, "_addr"}, BusAddr, 0);
    chk({tag, "_wdata"}, BusWData, 0);
    chk({tag, "_rd"}, RD, 0);
  endtask

  // Model: an access touches sz bytes starting at byte offset a%4 of the word.
  task automatic access(input bit mw, input logic [1:0] w, input bit sgn, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int dly, input bit inject);
    int          sz;
    bit          bad;
    logic [31:0] mask, be, wexp, rexp;
    int          busy_n;
    sz  = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
    bad = (w == 2'd3) || (a % sz != 0) || (a >= LIMIT);
    @(negedge Clk);
    Start = 1'b1; MemWrite = mw; OpWidth = w; LoadSigned = sgn; Addr = a; WD = wd;
    @(negedge Clk);
    Start = 1'b0;
    if (bad) begin
      chk("exc_done", Done, 1);
      chk("exc_flag", Exc, 1);
      chk("exc_code", ExcCode, mw ? 5 : 4);
      chk("exc_noreq", {BusReq, BusByteEn}, 0);
      chk("exc_rd", RD, rd_exp);
      @(negedge Clk);
      chk("exc_clear", {Busy, Done, Exc, ExcCode}, 0);
      return;
    end
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    be   = ((32'd1 << sz) - 32'd1) << (a % 4);
    wexp = (wd & mask) * ((sz == 4) ? 32'd1 : (sz == 2) ? 32'h0001_0001 : 32'h0101_0101);
    rexp = (rdata >> (8 * (a % 4))) & mask;
    if (sgn && sz < 4 && rexp[8*sz-1]) rexp = rexp | ~mask;
    busy_n = 0;
    for (int i = 0; i <= dly; i++) begin
      if (Busy) busy_n++;
      chk("req", BusReq, 1);
      chk("we", BusWE, mw);
      chk("addr", BusAddr, {a[31:2], 2'b00});
      chk("byteen", BusByteEn, be);
      chk("wdata", BusWData, wexp);
      chk("no_early_done", Done, 0);
      if (inject && i == 0) begin Start = 1'b1; Addr = a ^ 32'h40; end
      else begin Start = 1'b0; Addr = a; end
      if (i == dly) begin BusAck = 1'b1; BusRData = rdata; end
      else begin BusAck = 1'b0; BusRData = $urandom; end
      @(negedge Clk);
    end
    Start = 1'b0; BusAck = 1'b0;
    if (Busy) busy_n++;
    if (!mw) rd_exp = rexp;
    chk("done", Done, 1);
    chk("ok_exc", {Exc, ExcCode}, 0);
    chk("ack_clear", {BusReq, BusWE, BusByteEn}, 0);
    chk("rd", RD, rd_exp);
    @(negedge Clk);
    chk("busy_cycles", busy_n, dly + 2);
    chk("idle", {Busy, Done}, 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MemWrite = 1'b0; OpWidth = 2'b00; LoadSigned = 1'b0;
    Addr = '0; WD = '0; BusAck = 1'b0; BusRData = '0; rd_exp = '0;
    repeat (2) @(negedge Clk);
    chk_all_zero("reset");
    Reset = 1'b0;

    access(1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 2, 1'b0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b0);
    access(1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);
    access(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 0, 1'b0);
    access(1'b0, 2'b01, 1'b1, 32'h0000_2FFE, 32'h0, 32'h9ABC_8001, 1, 1'b0);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0044, 32'h0, 32'h1234_5678, 3, 1'b1);

    // Reset in the middle of REQ, then a stray ack that must be ignored
    @(negedge Clk);
    Start = 1'b1; MemWrite = 1'b0; OpWidth = 2'b00; Addr = 32'h20;
    @(negedge Clk);
    Start = 1'b0;
    chk("mid_req", BusReq, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; BusAck = 1'b1; BusRData = 32'hFFFF_FFFF;
    rd_exp = '0;
    chk_all_zero("mid_reset");
    @(negedge Clk);
    BusAck = 1'b0;
    chk("stray_ack", {Busy, Done, BusReq}, 0);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    // No ack: watchdog fires after 16 REQ cycles, or REQ waits indefinitely
    @(negedge Clk);
    Start = 1'b1; MemWrite = 1'b0; OpWidth = 2'b00; Addr = 32'h10;
    @(negedge Clk);
    Start = 1'b0;
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("tmo_req", BusReq, 1);
      @(negedge Clk);
    end
    chk("tmo_done", Done, 1);
    chk("tmo_exc", Exc, 1);
    chk("tmo_code", ExcCode, 7);
    chk("tmo_req_low", BusReq, 0);
    chk("tmo_rd", RD, rd_exp);
    @(negedge Clk);
    chk("tmo_idle", {Busy, Done, Exc}, 0);
`else
    for (int i = 0; i < 105; i++) begin
      chk("hang_req", {BusReq, Done}, 2'b10);
      @(negedge Clk);
    end
    BusAck = 1'b1; BusRData = 32'h0BAD_F00D;
    @(negedge Clk);
    BusAck = 1'b0;
    rd_exp = 32'h0BAD_F00D;
    chk("hang_done", Done, 1);
    chk("hang_rd", RD, rd_exp);
    @(negedge Clk);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  w;
      logic [31:0] a;
      w = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 32'h3100);
      if ($urandom_range(0, 3) != 0) a = a & ((w == 2'd0) ? ~32'd3 : (w == 2'd1) ? ~32'd1 : ~32'd0);
      access(1'($urandom), w, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3),
             1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
